// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI byte engine between two requesters, with enforced CS-high gap.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a transaction whose engine never reports done.
module spi_bus_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4095,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req0,
    input  logic [15:0] i_txdata0,
    output logic        o_ack0,
    output logic [7:0]  o_rxdata0,
    input  logic        i_req1,
    input  logic [15:0] i_txdata1,
    output logic        o_ack1,
    output logic [7:0]  o_rxdata1,
    output logic        o_spi_transmit,
    output logic [15:0] o_spi_txdata,
    input  logic        i_spi_done,
    input  logic [7:0]  i_spi_rxdata,
    output logic        o_spi_sel,
    output logic        o_busy,
    output logic        o_timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
    state_t      r_state, w_state;
    logic        r_last, w_last, r_sel, w_sel, r_transmit, w_transmit;
    logic        r_ack0, w_ack0, r_ack1, w_ack1, r_busy, w_busy;
    logic [15:0] r_txdata, w_txdata;
    logic [7:0]  r_rx0, w_rx0, r_rx1, w_rx1, w_rxbyte;
    logic [11:0] r_gap, w_gap;
    logic        w_winner, w_expire;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        r_terr;
    // a done pulse on the expiry cycle takes priority over the abort
    assign w_expire = (r_state == WAIT_DONE) && !i_spi_done && (r_wdog == 16'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_terr <= 1'b0;
        end else begin
            r_wdog <= (r_state == WAIT_DONE && !w_expire) ? r_wdog + 16'd1 : '0;
            r_terr <= w_expire;
        end
    end
    assign o_timeout_err = r_terr;
`else
    assign w_expire      = 1'b0;
    assign o_timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif
    always_comb begin
        w_state    = r_state;
        w_last     = r_last;
        w_sel      = r_sel;
        w_txdata   = r_txdata;
        w_transmit = 1'b0;
        w_ack0     = 1'b0;
        w_ack1     = 1'b0;
        w_rx0      = r_rx0;
        w_rx1      = r_rx1;
        w_busy     = r_busy;
        w_gap      = r_gap;
        w_winner   = (i_req0 && i_req1) ? ~r_last : i_req1;
        w_rxbyte   = i_spi_done ? i_spi_rxdata : 8'h00;
        case (r_state)
            IDLE: if (i_req0 || i_req1) begin
                w_state    = ISSUE;
                w_sel      = w_winner;
                w_last     = w_winner;
                w_txdata   = w_winner ? i_txdata1 : i_txdata0;
                w_transmit = 1'b1;
                w_busy     = 1'b1;
            end
            ISSUE: w_state = WAIT_DONE;
            WAIT_DONE: if (i_spi_done || w_expire) begin
                w_state = GAP;
                w_gap   = '0;
                w_ack0  = ~r_sel;
                w_ack1  = r_sel;
                w_rx0   = r_sel ? r_rx0 : w_rxbyte;
                w_rx1   = r_sel ? w_rxbyte : r_rx1;
            end
            GAP: begin
                w_state = (r_gap == 12'(GAP_CYCLES - 1)) ? IDLE : GAP;
                w_busy  = (r_gap != 12'(GAP_CYCLES - 1));
                w_gap   = (r_gap == 12'(GAP_CYCLES - 1)) ? '0 : r_gap + 12'd1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_txdata   <= '0;
            r_transmit <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rx0      <= '0;
            r_rx1      <= '0;
            r_busy     <= 1'b0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state;
            r_last     <= w_last;
            r_sel      <= w_sel;
            r_txdata   <= w_txdata;
            r_transmit <= w_transmit;
            r_ack0     <= w_ack0;
            r_ack1     <= w_ack1;
            r_rx0      <= w_rx0;
            r_rx1      <= w_rx1;
            r_busy     <= w_busy;
            r_gap      <= w_gap;
        end
    end
    assign o_ack0         = r_ack0;
    assign o_ack1         = r_ack1;
    assign o_rxdata0      = r_rx0;
    assign o_rxdata1      = r_rx1;
    assign o_spi_transmit = r_transmit;
    assign o_spi_txdata   = r_txdata;
    assign o_spi_sel      = r_sel;
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: table-driven arbitration vectors plus hand sequences, checked by grant/ack scoreboards.
module tb_spi_bus_arbiter;
    localparam int GAP = 8;
    localparam int TMO = 16;
    localparam int LAT = 10;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req0 = 1'b0, i_req1 = 1'b0, i_spi_done = 1'b0;
    logic [15:0] i_txdata0 = '0, i_txdata1 = '0;
    logic [7:0]  i_spi_rxdata = '0;
    logic        o_ack0, o_ack1, o_spi_transmit, o_spi_sel, o_busy, o_timeout_err;
    logic [7:0]  o_rxdata0, o_rxdata1;
    logic [15:0] o_spi_txdata;

    spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req0(i_req0), .i_txdata0(i_txdata0), .o_ack0(o_ack0), .o_rxdata0(o_rxdata0),
        .i_req1(i_req1), .i_txdata1(i_txdata1), .o_ack1(o_ack1), .o_rxdata1(o_rxdata1),
        .o_spi_transmit(o_spi_transmit), .o_spi_txdata(o_spi_txdata),
        .i_spi_done(i_spi_done), .i_spi_rxdata(i_spi_rxdata),
        .o_spi_sel(o_spi_sel), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic r0; logic r1; logic [15:0] t0; logic [15:0] t1; logic [7:0] rx; logic sel; } vec_t;
    typedef struct { logic sel; logic [15:0] tx; } grant_t;
    typedef struct { logic sel; logic [7:0] rx; logic terr; } ack_t;

    grant_t     grant_q[$];
    ack_t       ack_q[$];
    logic [7:0] eng_q[$];
    int         n_chk = 0, n_err = 0, eng_cnt = 0;
    logic [7:0] eng_rx = '0, rx0_m = '0, rx1_m = '0;
    bit         saw_ack, saw_tx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {o_ack0, o_ack1, o_rxdata0, o_rxdata1, o_spi_transmit, o_spi_txdata,
                   o_spi_sel, o_busy, o_timeout_err}, 64'd0);
    endtask

    // one clock: engine model, then scoreboard checks of whatever the DUT shows this cycle
    task automatic tick();
        grant_t g;
        ack_t   a;
        @(negedge clk);
        saw_ack    = 0;
        saw_tx     = 0;
        i_spi_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                i_spi_done   = 1'b1;
                i_spi_rxdata = eng_rx;
            end
        end
        if (!rst) begin
            if (o_spi_transmit) begin
                saw_tx = 1;
                if (eng_q.size() > 0) begin
                    eng_rx  = eng_q.pop_front();
                    eng_cnt = LAT;
                end
                if (grant_q.size() == 0) chk("unexpected_transmit", o_spi_transmit, 0);
                else begin
                    g = grant_q.pop_front();
                    chk("grant_sel", o_spi_sel, g.sel);
                    chk("grant_txdata", o_spi_txdata, g.tx);
                end
            end
            if (o_ack0 || o_ack1) begin
                saw_ack = 1;
                if (ack_q.size() == 0) chk("unexpected_ack", {o_ack0, o_ack1}, 0);
                else begin
                    a = ack_q.pop_front();
                    chk("ack_dir", {o_ack0, o_ack1}, a.sel ? 2'b01 : 2'b10);
                    chk("ack_timeout_err", o_timeout_err, a.terr);
                    if (a.sel) rx1_m = a.rx;
                    else rx0_m = a.rx;
                    chk("rxdata0", o_rxdata0, rx0_m);
                    chk("rxdata1", o_rxdata1, rx1_m);
                end
            end
        end
    endtask

    task automatic wait_tx();
        int n = 0;
        do begin tick(); n++; end while (!saw_tx && n < 100);
        chk("transmit_seen", saw_tx, 1);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin tick(); n++; end while (!saw_ack && n < 200);
        chk("ack_seen", saw_ack, 1);
    endtask

    task automatic push_txn(input logic sel, input logic [15:0] tx, input logic [7:0] rx, input bit respond);
        grant_t g;
        ack_t   a;
        g.sel = sel; g.tx = tx;
        grant_q.push_back(g);
        if (respond) begin
            a.sel = sel; a.rx = rx; a.terr = 1'b0;
            ack_q.push_back(a);
            eng_q.push_back(rx);
        end
    endtask

    task automatic run_vec(input vec_t v);
        i_req0 = v.r0; i_req1 = v.r1; i_txdata0 = v.t0; i_txdata1 = v.t1;
        push_txn(v.sel, v.sel ? v.t1 : v.t0, v.rx, 1);
        wait_ack();
        if (v.sel) i_req1 = 1'b0;
        else i_req0 = 1'b0;
    endtask

    // called on the ack cycle; busy must stay high for exactly GAP more cycles
    task automatic measure_gap(input int stray_at);
        int n = 0;
        while (o_busy && n < 100) begin
            tick();
            n++;
            if (n == stray_at) begin i_spi_done = 1'b1; i_spi_rxdata = 8'hEE; end
        end
        chk("gap_length", n, GAP);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin tick(); n++; end
        chk("idle_reached", o_busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        rx0_m = '0; rx1_m = '0; eng_cnt = 0;
        grant_q.delete(); ack_q.delete(); eng_q.delete();
    endtask

    initial begin
        vec_t tbl [11];
        tbl[0]  = '{1'b1, 1'b1, 16'h2D08, 16'hB500, 8'h11, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h2D08, 16'hB500, 8'h22, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 16'h1111, 16'h2222, 8'h31, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h3333, 16'h2222, 8'h32, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 16'h3333, 16'h4444, 8'h33, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h5555, 16'h4444, 8'h34, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 16'h5555, 16'h6666, 8'h35, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'h7070, 16'h6666, 8'h36, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 16'h0000, 16'h7777, 8'h41, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h8888, 8'h42, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 16'h0000, 16'h9999, 8'h43, 1'b1};

        tick(); tick();
        chk_zero("reset_outputs");
        rst = 1'b0;
        tick();
        chk("idle_after_reset", o_busy, 0);

        run_vec('{1'b1, 1'b0, 16'hB400, 16'h0000, 8'h5A, 1'b0});
        measure_gap(0);

        do_reset();
        for (int i = 0; i < 11; i++) run_vec(tbl[i]);
        wait_idle();

        i_spi_done = 1'b1; i_spi_rxdata = 8'hEE;
        tick(); tick();
        chk("stray_idle_busy", o_busy, 0);
        chk("stray_idle_rx0", o_rxdata0, rx0_m);
        chk("stray_idle_rx1", o_rxdata1, rx1_m);

        i_req0 = 1'b1; i_txdata0 = 16'hC0DE;
        push_txn(1'b0, 16'hC0DE, 8'h33, 1);
        wait_tx();
        i_spi_done = 1'b1; i_spi_rxdata = 8'hEE;
        wait_ack();
        i_req0 = 1'b0;
        measure_gap(3);

        i_req0 = 1'b1; i_txdata0 = 16'h1234;
        push_txn(1'b0, 16'h1234, 8'h00, 0);
        eng_q.push_back(8'h77);
        wait_tx();
        tick(); tick(); tick();
        rst = 1'b1; i_req0 = 1'b0;
        #1 chk_zero("mid_transaction_reset");
        tick();
        rst = 1'b0; rx0_m = '0; rx1_m = '0;
        repeat (15) tick();
        chk("post_reset_idle", o_busy, 0);
        chk("post_reset_rx0", o_rxdata0, 0);
        run_vec('{1'b1, 1'b0, 16'hABCD, 16'h0000, 8'h44, 1'b0});

        run_vec('{1'b0, 1'b1, 16'h0000, 16'h5555, 8'h99, 1'b1});
        i_req1 = 1'b1; i_txdata1 = 16'h0F0F;
        push_txn(1'b1, 16'h0F0F, 8'h00, 0);
`ifdef SPI_ARB_TIMEOUT_EN
        begin
            ack_t a;
            int   n = 0;
            a.sel = 1'b1; a.rx = 8'h00; a.terr = 1'b1;
            ack_q.push_back(a);
            wait_tx();
            do begin tick(); n++; end while (!saw_ack && n < 100);
            chk("timeout_latency", n, TMO + 1);
        end
`else
        wait_tx();
        repeat (40) tick();
        chk("no_timeout_busy", o_busy, 1);
        chk("no_timeout_rx1", o_rxdata1, rx1_m);
`endif
        i_req1 = 1'b0;
        chk("scoreboard_drained", grant_q.size() + ack_q.size(), 0);
        do_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI byte-transfer engine between two independent requesters, e.g. the accelerometer sequencer and a second Pmod controller.
- Engine interface: `transmit` pulse and 16-bit command word out; `done` pulse and 8-bit read byte back.
- Round-robin arbitration; one transaction in flight; enforced inter-transaction gap (ADXL345 CS-high time); drives the slave-select steering bit for the SS mux.

Parameters:
GAP_CYCLES, 4095, idle cycles after each completed transaction before re-arbitration; legal 2..4095 (12-bit counter)
TIMEOUT_CYCLES, 65535, max cycles waiting for spi_done (only with SPI_ARB_TIMEOUT_EN); legal 16..65535

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 transaction request, level, held until ack0
txdata0  in  16  requester 0 command word, stable while req0 high
ack0  out  1  one-cycle completion pulse to requester 0
rxdata0  out  8  byte read for requester 0, valid with ack0, held until next ack0
req1  in  1  requester 1 request
txdata1  in  16  requester 1 command word
ack1  out  1  requester 1 completion pulse
rxdata1  out  8  requester 1 read byte
spi_transmit  out  1  one-cycle start pulse to SPI engine
spi_txdata  out  16  command word to engine, held through transaction
spi_done  in  1  engine completion pulse
spi_rxdata  in  8  engine read byte, valid with spi_done
spi_sel  out  1  owner of bus (0/1), steers SS mux, held through GAP
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse with ack on watchdog abort; constant 0 without SPI_ARB_TIMEOUT_EN

Behaviour:
- Reset, async and any time including mid-transaction:
  - All outputs 0; state IDLE; counters 0; rr pointer last=1, so requester 0 wins the first tie.
  - Engine is not notified; any later spi_done is ignored in IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - No req: stay.
  - Any req sampled at cycle T: winner = the only requester, or if both, the one != last.
  - At T+1: state ISSUE; spi_sel = winner; spi_txdata = winner's txdata, captured at T; spi_transmit = 1; busy = 1; last = winner.
- ISSUE: lasts exactly one cycle; next state WAIT_DONE, spi_transmit returns to 0.
- WAIT_DONE:
  - spi_done sampled at cycle D: at D+1, ack[winner] = 1 for one cycle and rxdata[winner] = spi_rxdata captured at D; state GAP; gap counter cleared.
  - Other requester's rxdata unchanged.
- GAP:
  - Counter increments each cycle; on reaching GAP_CYCLES-1, next state IDLE, busy = 0.
  - spi_sel holds its value; spi_txdata holds its value.
- Latency, uncontended: req high at T -> spi_transmit at T+1 -> ack at D+1 -> next grant no earlier than D+2+GAP_CYCLES.
- spi_done in IDLE, ISSUE or GAP: ignored.
- spi_done coincident with the spi_transmit cycle: ignored; only WAIT_DONE accepts it.
- Requester contract:
  - Deassert req within one cycle after ack.
  - req still high when IDLE is re-entered counts as a new request.
  - txdata changes while req is high are not seen after capture.
- Fairness: continuous requests from both sides alternate 0,1,0,1,…; a lone requester is granted back-to-back regardless of last.
- Request withdrawn before grant: no transaction.
- Request withdrawn after grant: transaction completes and ack is still issued.

Optional Feature:
SPI_ARB_TIMEOUT_EN:
- Defined:
  - 16-bit watchdog counts in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 without spi_done: next cycle ack[winner] = 1, timeout_err = 1 (one cycle), rxdata[winner] = 8'h00; state GAP.
  - spi_done arriving on the same cycle as expiry wins: normal completion, no timeout_err.
- Undefined: WAIT_DONE waits indefinitely; timeout_err tied 0; no counter logic.

Test Plan:
- Reset, then req0=1, txdata0=16'hB400; engine returns spi_done with spi_rxdata=8'h5A 10 cycles after transmit -> spi_transmit one pulse, spi_txdata=B400, spi_sel=0, ack0 pulse, rxdata0=5A, busy low exactly GAP_CYCLES cycles after ack.
- req0 and req1 rise same cycle after reset (txdata0=2D08, txdata1=B500) -> requester 0 served first, requester 1 after gap; rxdata0 unchanged by requester 1's transfer.
- Both requests held continuously for 6 transactions -> grant order 0,1,0,1,0,1; only req1 held for 3 -> spi_sel=1 three times.
- Stray spi_done pulses in IDLE, in ISSUE cycle, and mid-GAP -> no ack, no rxdata change, no state change.
- Assert rst during WAIT_DONE, then deliver spi_done after release -> all outputs 0 immediately, no ack produced, next req0 arbitrates normally.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never responds -> ack1 and timeout_err pulse together 17 cycles after spi_transmit, rxdata1=00; without macro the bench sees busy held high, no ack.
